// File: rtl/ex_stage.sv
// Execute stage: one-entry EX register with valid/allow-in handshake, ALU, branch resolution and wrong-path squash.
// Optional iterative multiplier for op 12 is enabled by defining EX_MUL_EN.
module ex_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         ds_to_ex_reg_valid,
  input  logic [131:0] ds_ex_reg_data,
  output logic         ds_ex_reg_allow_in,
  output logic         es_to_ms_valid,
  input  logic         ms_allow_in,
  output logic [63:0]  es_ms_reg_data,
  output logic [32:0]  branch_data
);

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_BNE  = 4'd7;
  localparam logic [3:0] OP_BLT  = 4'd8;
  localparam logic [3:0] OP_BGE  = 4'd9;
  localparam logic [3:0] OP_JAL  = 4'd10;
  localparam logic [3:0] OP_JALR = 4'd11;
`ifdef EX_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd12;

  function automatic logic [DATA_W-1:0] mul_lo(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] prod;
    prod = a * b;
    return prod[DATA_W-1:0];
  endfunction
`endif

  logic               vld_p0;
  logic [131:0]       payload_p0;
  logic               squash_pending_p0;

  logic [3:0]         op;
  logic [DATA_W-1:0]  imm, rs2_val, rs1_val, pc;
  logic signed [DATA_W-1:0] rs1_s, rs2_s;
  logic [DATA_W-1:0]  result, target;
  logic               taken;
  logic               es_ready_go;
  logic               in_fire, out_fire, squash_hit;

  assign op      = payload_p0[131:128];
  assign imm     = payload_p0[127:96];
  assign rs2_val = payload_p0[95:64];
  assign rs1_val = payload_p0[63:32];
  assign pc      = payload_p0[31:0];
  assign rs1_s   = signed'(rs1_val);
  assign rs2_s   = signed'(rs2_val);

  always_comb begin
    result = '0;
    target = pc + imm;
    taken  = 1'b0;
    case (op)
      OP_ADD:  result = rs1_val + rs2_val;
      OP_SUB:  result = rs1_val - rs2_val;
      OP_AND:  result = rs1_val & rs2_val;
      OP_OR:   result = rs1_val | rs2_val;
      OP_XOR:  result = rs1_val ^ rs2_val;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, rs1_s < rs2_s};
      OP_BEQ:  taken  = (rs1_val == rs2_val);
      OP_BNE:  taken  = (rs1_val != rs2_val);
      OP_BLT:  taken  = (rs1_s < rs2_s);
      OP_BGE:  taken  = (rs1_s >= rs2_s);
      OP_JAL: begin
        result = pc + 32'd4;
        taken  = 1'b1;
      end
      OP_JALR: begin
        result = pc + 32'd4;
        target = (rs1_val + imm) & ~32'd1;
        taken  = 1'b1;
      end
`ifdef EX_MUL_EN
      OP_MUL:  result = mul_lo(rs1_val, rs2_val);
`endif
      default: result = '0;
    endcase
  end

`ifdef EX_MUL_EN
  logic [1:0] mul_cnt_p0;

  // MUL sits in EX until the counter reaches 3; other ops leave immediately.
  assign es_ready_go = (op != OP_MUL) || (mul_cnt_p0 == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_cnt_p0 <= 2'd0;
    end else if (out_fire) begin
      mul_cnt_p0 <= 2'd0;
    end else if (vld_p0 && op == OP_MUL && mul_cnt_p0 != 2'd3) begin
      mul_cnt_p0 <= mul_cnt_p0 + 2'd1;
    end
  end
`else
  assign es_ready_go = 1'b1;
`endif

  assign ds_ex_reg_allow_in = !vld_p0 || (es_ready_go && ms_allow_in);
  assign es_to_ms_valid     = vld_p0 && es_ready_go;
  assign in_fire            = ds_to_ex_reg_valid && ds_ex_reg_allow_in;
  assign out_fire           = es_to_ms_valid && ms_allow_in;
  assign squash_hit         = squash_pending_p0 || (out_fire && taken);

  assign es_ms_reg_data = {result, pc};
  assign branch_data    = (out_fire && taken) ? {1'b1, target} : 33'h0;

  // EX register: a taken branch drops exactly the next accepted instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0            <= 1'b0;
      payload_p0        <= '0;
      squash_pending_p0 <= 1'b0;
    end else if (in_fire) begin
      payload_p0        <= ds_ex_reg_data;
      vld_p0            <= !squash_hit;
      squash_pending_p0 <= 1'b0;
    end else begin
      if (out_fire)
        vld_p0 <= 1'b0;
      if (out_fire && taken)
        squash_pending_p0 <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU/branch vector table plus back-pressure, squash, MUL and reset sequences.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ds_to_ex_reg_valid;
  logic [131:0] ds_ex_reg_data;
  logic         ds_ex_reg_allow_in;
  logic         es_to_ms_valid;
  logic         ms_allow_in;
  logic [63:0]  es_ms_reg_data;
  logic [32:0]  branch_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                (clk),
    .reset              (reset),
    .ds_to_ex_reg_valid (ds_to_ex_reg_valid),
    .ds_ex_reg_data     (ds_ex_reg_data),
    .ds_ex_reg_allow_in (ds_ex_reg_allow_in),
    .es_to_ms_valid     (es_to_ms_valid),
    .ms_allow_in        (ms_allow_in),
    .es_ms_reg_data     (es_ms_reg_data),
    .branch_data        (branch_data)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic [31:0] res;
    logic [32:0] br;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] imm, input logic [31:0] rs2,
                              input logic [31:0] rs1, input logic [31:0] pc, input logic [31:0] res,
                              input logic [32:0] br);
    vec_t v;
    v.op = op; v.imm = imm; v.rs2 = rs2; v.rs1 = rs1; v.pc = pc; v.res = res; v.br = br;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] imm, input logic [31:0] rs2,
                      input logic [31:0] rs1, input logic [31:0] pc);
    ds_ex_reg_data     = {op, imm, rs2, rs1, pc};
    ds_to_ex_reg_valid = 1'b1;
    @(posedge clk);
    #1;
    ds_to_ex_reg_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(es_to_ms_valid), 64'd0);
    chk({tag, "_allow"}, 64'(ds_ex_reg_allow_in), 64'd1);
    chk({tag, "_data"},  es_ms_reg_data, 64'h0);
    chk({tag, "_br"},    64'(branch_data), 64'h0);
  endtask

  initial begin
    reset              = 1'b1;
    ds_to_ex_reg_valid = 1'b0;
    ds_ex_reg_data     = '0;
    ms_allow_in        = 1'b1;

    vecs.push_back(mk(4'd0,  32'h0,        32'd7,        32'd5,        32'h100, 32'h0000000C, 33'h0));
    vecs.push_back(mk(4'd1,  32'h0,        32'd5,        32'd3,        32'h104, 32'hFFFFFFFE, 33'h0));
    vecs.push_back(mk(4'd2,  32'h0,        32'hFF00,     32'hF0F0,     32'h108, 32'h0000F000, 33'h0));
    vecs.push_back(mk(4'd3,  32'h0,        32'h0F00,     32'hF0F0,     32'h10C, 32'h0000FFF0, 33'h0));
    vecs.push_back(mk(4'd4,  32'h0,        32'h0F,       32'hFF,       32'h110, 32'h000000F0, 33'h0));
    vecs.push_back(mk(4'd5,  32'h0,        32'd1,        32'hFFFFFFFF, 32'h114, 32'h1,        33'h0));
    vecs.push_back(mk(4'd5,  32'h0,        32'hFFFFFFFF, 32'd1,        32'h118, 32'h0,        33'h0));
    vecs.push_back(mk(4'd0,  32'h0,        32'd2,        32'hFFFFFFFF, 32'h11C, 32'h1,        33'h0));
    vecs.push_back(mk(4'd6,  32'h40,       32'd3,        32'd3,        32'h200, 32'h0,        33'h1_00000240));
    vecs.push_back(mk(4'd7,  32'h10,       32'd3,        32'd3,        32'h210, 32'h0,        33'h0));
    vecs.push_back(mk(4'd8,  32'hFFFFFFF0, 32'd1,        32'hFFFFFFFE, 32'h400, 32'h0,        33'h1_000003F0));
    vecs.push_back(mk(4'd9,  32'h8,        32'd1,        32'hFFFFFFFE, 32'h500, 32'h0,        33'h0));
    vecs.push_back(mk(4'd10, 32'h20,       32'd0,        32'd0,        32'h600, 32'h604,      33'h1_00000620));
`ifndef EX_MUL_EN
    vecs.push_back(mk(4'd12, 32'h0,        32'h10001,    32'h10000,    32'h680, 32'h0,        33'h0));
`endif
    vecs.push_back(mk(4'd13, 32'h0,        32'd7,        32'd5,        32'h700, 32'h0,        33'h0));

    tick();
    tick();
    chk_reset_outputs("in_reset");
    reset = 1'b0;
    tick();
    chk_reset_outputs("post_reset");

    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].imm, vecs[i].rs2, vecs[i].rs1, vecs[i].pc);
      chk($sformatf("vec%0d_valid", i), 64'(es_to_ms_valid), 64'd1);
      chk($sformatf("vec%0d_data", i), es_ms_reg_data, {vecs[i].res, vecs[i].pc});
      chk($sformatf("vec%0d_br", i), 64'(branch_data), 64'(vecs[i].br));
      if (vecs[i].br[32]) begin
        tick();
        chk($sformatf("vec%0d_br_pulse", i), 64'(branch_data), 64'h0);
        send(4'd0, 32'h0, 32'd1, 32'd1, 32'hDEAD0000);
        chk($sformatf("vec%0d_squash", i), 64'(es_to_ms_valid), 64'd0);
      end
    end
    tick();
    chk("idle_valid", 64'(es_to_ms_valid), 64'd0);

    // JALR under back-pressure, with a younger instruction waiting upstream
    ms_allow_in = 1'b0;
    send(4'd11, 32'd4, 32'd0, 32'h1001, 32'h300);
    ds_ex_reg_data     = {4'd0, 32'h0, 32'd1, 32'd1, 32'h999};
    ds_to_ex_reg_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp%0d_allow", c), 64'(ds_ex_reg_allow_in), 64'd0);
      chk($sformatf("bp%0d_valid", c), 64'(es_to_ms_valid), 64'd1);
      chk($sformatf("bp%0d_data", c), es_ms_reg_data, 64'h00000304_00000300);
      chk($sformatf("bp%0d_br", c), 64'(branch_data), 64'h0);
      tick();
    end
    ms_allow_in = 1'b1;
    #1;
    chk("bp_rel_br", 64'(branch_data), 64'h1_00001004);
    chk("bp_rel_data", es_ms_reg_data, 64'h00000304_00000300);
    chk("bp_rel_allow", 64'(ds_ex_reg_allow_in), 64'd1);
    tick();
    ds_to_ex_reg_valid = 1'b0;
    chk("same_cycle_squash_valid", 64'(es_to_ms_valid), 64'd0);
    chk("same_cycle_squash_br", 64'(branch_data), 64'h0);
    send(4'd0, 32'h0, 32'd2, 32'd1, 32'h720);
    chk("after_squash_valid", 64'(es_to_ms_valid), 64'd1);
    chk("after_squash_data", es_ms_reg_data, 64'h00000003_00000720);
    tick();

    send(4'd12, 32'h0, 32'h10001, 32'h10000, 32'h800);
`ifdef EX_MUL_EN
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("mul_wait%0d_valid", c), 64'(es_to_ms_valid), 64'd0);
      chk($sformatf("mul_wait%0d_allow", c), 64'(ds_ex_reg_allow_in), 64'd0);
      tick();
    end
    chk("mul_valid", 64'(es_to_ms_valid), 64'd1);
    chk("mul_data", es_ms_reg_data, 64'h00010000_00000800);
`else
    chk("mul_valid", 64'(es_to_ms_valid), 64'd1);
    chk("mul_data", es_ms_reg_data, 64'h00000000_00000800);
`endif
    tick();

    // reset in the middle of a MUL
    send(4'd12, 32'h0, 32'h3, 32'h5, 32'h900);
    tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs("mid_mul_reset");
    reset = 1'b0;
    send(4'd0, 32'h0, 32'd7, 32'd5, 32'hA00);
    chk("post_mul_reset_valid", 64'(es_to_ms_valid), 64'd1);
    chk("post_mul_reset_data", es_ms_reg_data, 64'h0000000C_00000A00);
    tick();

    // reset while a squash is pending
    send(4'd6, 32'h10, 32'd1, 32'd1, 32'hB00);
    chk("pend_br", 64'(branch_data), 64'h1_00000B10);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send(4'd0, 32'h0, 32'd2, 32'd2, 32'hC00);
    chk("post_pend_reset_valid", 64'(es_to_ms_valid), 64'd1);
    chk("post_pend_reset_data", es_ms_reg_data, 64'h00000004_00000C00);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
REQ-002 ds_to_ex_reg_valid, input, 1: decode stage offers an instruction.
REQ-003 ds_ex_reg_data, input, 132: {op[131:128], imm[127:96], rs2_val[95:64], rs1_val[63:32], pc[31:0]}.
REQ-004 ds_ex_reg_allow_in, output, 1: EX can accept this cycle.
REQ-005 es_to_ms_valid, output, 1: EX offers a result to memory stage.
REQ-006 ms_allow_in, input, 1: memory stage can accept this cycle.
REQ-007 es_ms_reg_data, output, 64: {result[63:32], pc[31:0]}.
REQ-008 branch_data, output, 33: {taken[32], target[31:0]} to fetch stage.

Function
REQ-009 The block SHALL hold one EX register (es_valid plus a 132-bit payload); in_fire = ds_to_ex_reg_valid & ds_ex_reg_allow_in; out_fire = es_to_ms_valid & ms_allow_in.
REQ-010 Handshake: ds_ex_reg_allow_in = !es_valid | (es_ready_go & ms_allow_in), and es_to_ms_valid = es_valid & es_ready_go.
REQ-011 On in_fire the payload SHALL be latched; es_valid <= !squash_hit. On out_fire without in_fire, es_valid <= 0. Otherwise the state holds.
REQ-012 Ops SHALL be decoded as follows. All arithmetic is modulo 2^32. SLT, BLT and BGE are signed.
- 0 ADD rs1+rs2
- 1 SUB rs1-rs2
- 2 AND
- 3 OR
- 4 XOR
- 5 SLT (result 1/0)
- 6 BEQ
- 7 BNE
- 8 BLT
- 9 BGE
- 10 JAL
- 11 JALR
- 12 MUL
- 13-15 reserved
REQ-013 Branches (6-9) SHALL produce result 0 and target pc+imm. JAL SHALL produce result pc+4 and target pc+imm. JALR SHALL produce result pc+4 and target (rs1+imm)&~1. Reserved ops SHALL produce result 0 and are never taken.
REQ-014 taken SHALL be the branch condition for ops 6-9, and 1 for ops 10-11.
REQ-015 branch_data SHALL equal {1, target} only in a cycle where out_fire & taken; otherwise it SHALL be 33'h0. It is a single-cycle pulse per branch.
REQ-016 Squash: a taken out_fire SHALL set squash_pending. The first in_fire in the same cycle or any later cycle (squash_hit = squash_pending | taken out_fire) SHALL be discarded (es_valid <= 0), and squash_pending SHALL then clear. Exactly one wrong-path instruction is dropped per taken branch.
REQ-017 A taken out_fire with a simultaneous in_fire SHALL drop that incoming instruction and leave squash_pending 0.
REQ-018 Back-pressure: while es_valid & !ms_allow_in, the payload, es_ms_reg_data and the MUL counter SHALL hold, and branch_data SHALL stay 0.
REQ-019 es_ready_go SHALL be 1 for every op except MUL under REQ-023.

Reset
REQ-020 While reset=1 at a clock edge, the following SHALL clear to 0: es_valid, squash_pending, the MUL counter and the payload.
REQ-021 Outputs during and after reset SHALL be: es_to_ms_valid=0, ds_ex_reg_allow_in=1, es_ms_reg_data=64'h0, branch_data=33'h0.
REQ-022 Reset mid-MUL or with squash pending SHALL abandon the operation, and the next instruction SHALL be accepted normally.

Configuration
REQ-023 Macro EX_MUL_EN defined: op 12 SHALL produce the low 32 bits of rs1*rs2 after a 2-bit counter counts 0..3. es_ready_go SHALL be 1 only at count 3, giving 4 cycles of EX residency minimum. The counter SHALL reset to 0 on out_fire.
REQ-024 Macro EX_MUL_EN undefined: op 12 SHALL be treated as reserved (result 0, single cycle), and no multiplier or counter SHALL be instantiated.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- ADD: pc=0x100, rs1=5, rs2=7, ms_allow_in=1 -> next cycle es_to_ms_valid=1, es_ms_reg_data={0x0000000C, 0x00000100}, branch_data=0.
- BEQ taken: pc=0x200, rs1=rs2=3, imm=0x40 -> branch_data=33'h1_00000240 for exactly one cycle. The following ds instruction (ADD) is dropped and never reaches es_to_ms_valid. The one after it passes.
- BNE not taken (rs1=rs2=3) -> branch_data stays 0 and no instruction is dropped.
- Back-pressure: ms_allow_in=0 for 3 cycles with JALR rs1=0x1001, imm=4, pc=0x300 -> ds_ex_reg_allow_in=0, data held, branch_data=0. On release: branch_data=33'h1_00001004 and result 0x304.
- EX_MUL_EN: MUL rs1=0x10000, rs2=0x10001 -> es_to_ms_valid rises on the 4th cycle with result 0x00010000. With the macro undefined, result is 0 after 1 cycle.
- Reset asserted mid-MUL -> all outputs reach their reset values at the next edge, and a following ADD completes in 1 cycle.
